// File: rtl/result_bcd_display.sv
// Captures a 16-bit ALU result and converts it to five packed BCD digits with a
// sequential shift-add-3 engine, then scans the digits onto a 5-digit common-anode display.
module result_bcd_display #(
    parameter int unsigned REFRESH_DIV   = 50000,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] result,
    input  logic        flag,
    input  logic        load,
    output logic        busy,
    output logic        done,
    output logic [19:0] bcd,
    output logic [6:0]  seg,
    output logic [4:0]  an,
    output logic        flag_led
);

    localparam int unsigned PRE_W = $clog2(REFRESH_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        FINISH
    } state_t;

    state_t      state_q,    state_d;
    logic [15:0] shift_q,    shift_d;
    logic [19:0] work_q,     work_d;
    logic [3:0]  cnt_q,      cnt_d;
    logic        busy_q,     busy_d;
    logic        done_q,     done_d;
    logic [19:0] bcd_q,      bcd_d;
    logic        flag_led_q, flag_led_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [2:0]  idx_q,      idx_d;

    logic [19:0] work_adj;
    logic [3:0]  digit;
    logic        lead_zero;
    logic [4:0]  an_sel;

    // Double-dabble correction: any BCD nibble >= 5 would overflow past 9 after the shift.
    function automatic logic [19:0] add3(input logic [19:0] w);
        logic [19:0] r;
        r = w;
        for (int i = 0; i < 5; i++) begin
            if (w[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = w[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    assign work_adj = add3(work_q);

    // Conversion FSM next-state logic.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        shift_d    = shift_q;
        work_d     = work_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        bcd_d      = bcd_q;
        flag_led_d = flag_led_q;

        case (state_q)
            IDLE: begin
                if (load) begin
                    shift_d    = result;
                    flag_led_d = flag;
                    work_d     = '0;
                    cnt_d      = '0;
                    busy_d     = 1'b1;
                    state_d    = CONVERT;
                end
            end
            CONVERT: begin
                {work_d, shift_d} = {work_adj[18:0], shift_q, 1'b0};
                cnt_d             = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                bcd_d   = work_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Free-running scan timebase, independent of the conversion.
    always_comb begin
        pre_d = pre_q + PRE_W'(1);
        idx_d = idx_q;
        if (pre_q == PRE_LAST) begin
            pre_d = '0;
            idx_d = (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            work_q     <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            flag_led_q <= 1'b0;
            pre_q      <= '0;
            idx_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q    <= state_d;
            shift_q    <= shift_d;
            work_q     <= work_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bcd_q      <= bcd_d;
            flag_led_q <= flag_led_d;
            pre_q      <= pre_d;
            idx_q      <= idx_d;
        end
    end

    // Digit select and leading-zero detection for the current scan slot.
    always_comb begin
        digit     = bcd_q[3:0];
        lead_zero = 1'b0;
        an_sel    = 5'b11110;
        case (idx_q)
            3'd1: begin
                digit     = bcd_q[7:4];
                lead_zero = (bcd_q[19:4] == 16'h0000);
                an_sel    = 5'b11101;
            end
            3'd2: begin
                digit     = bcd_q[11:8];
                lead_zero = (bcd_q[19:8] == 12'h000);
                an_sel    = 5'b11011;
            end
            3'd3: begin
                digit     = bcd_q[15:12];
                lead_zero = (bcd_q[19:12] == 8'h00);
                an_sel    = 5'b10111;
            end
            3'd4: begin
                digit     = bcd_q[19:16];
                lead_zero = (bcd_q[19:16] == 4'h0);
                an_sel    = 5'b01111;
            end
            default: begin
                digit     = bcd_q[3:0];
                lead_zero = 1'b0;
                an_sel    = 5'b11110;
            end
        endcase

        if (BLANK_LEADING && lead_zero) begin
            an  = 5'b11111;
            seg = SEG_BLANK;
        end else begin
            an  = an_sel;
            seg = seg_decode(digit);
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign flag_led = flag_led_q;

endmodule

// File: tb/tb_result_bcd_display.sv
// Randomized bench for result_bcd_display: an arithmetic decimal model predicts bcd,
// handshake timing and the scanned display for both blanking settings.
module tb_result_bcd_display;

    localparam int unsigned DIV = 4;

    logic        clk    = 1'b0;
    logic        rst    = 1'b0;
    logic [15:0] result = '0;
    logic        flag   = 1'b0;
    logic        load   = 1'b0;

    logic        busy,     done,     flag_led;
    logic [19:0] bcd;
    logic [6:0]  seg;
    logic [4:0]  an;
    logic        busy_nb,  done_nb,  flag_led_nb;
    logic [19:0] bcd_nb;
    logic [6:0]  seg_nb;
    logic [4:0]  an_nb;

    int n_checks = 0;
    int n_errors = 0;
    int edge_n;

    result_bcd_display #(.REFRESH_DIV(DIV), .BLANK_LEADING(1'b1)) dut (
        .clk(clk), .rst(rst), .result(result), .flag(flag), .load(load),
        .busy(busy), .done(done), .bcd(bcd), .seg(seg), .an(an), .flag_led(flag_led)
    );

    result_bcd_display #(.REFRESH_DIV(DIV), .BLANK_LEADING(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .result(result), .flag(flag), .load(load),
        .busy(busy_nb), .done(done_nb), .bcd(bcd_nb), .seg(seg_nb), .an(an_nb),
        .flag_led(flag_led_nb)
    );

    always #5 clk = ~clk;

    // Clock edges since reset release; the scan slot is a pure function of this count.
    always @(posedge clk or negedge rst) begin
        if (!rst) edge_n <= 0;
        else      edge_n <= edge_n + 1;
    end

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        int p;
        r = '0;
        p = 1;
        for (int k = 0; k < 5; k++) begin
            r[k*4 +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'h7F;
        endcase
    endfunction

    // Slot idx is blank exactly when the value has no decimal digit at or above position idx.
    task automatic exp_disp(input int v, input int idx, input bit blank_en,
                            output logic [4:0] a, output logic [6:0] s);
        int p;
        p = 1;
        for (int k = 0; k < idx; k++) p = p * 10;
        if (blank_en && idx != 0 && v < p) begin
            a = 5'b11111;
            s = 7'h7F;
        end else begin
            a      = 5'b11111;
            a[idx] = 1'b0;
            s      = seg_of((v / p) % 10);
        end
    endtask

    task automatic check_display(input int ncyc, input int v);
        logic [4:0] ea;
        logic [6:0] es;
        int idx;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            idx = (edge_n / DIV) % 5;
            exp_disp(v, idx, 1'b1, ea, es);
            n_checks++;
            if (an !== ea || seg !== es) begin
                n_errors++;
                $display("FAIL disp_blank v=%0d slot=%0d: an=%b seg=%b, expected an=%b seg=%b",
                         v, idx, an, seg, ea, es);
            end
            exp_disp(v, idx, 1'b0, ea, es);
            n_checks++;
            if (an_nb !== ea || seg_nb !== es) begin
                n_errors++;
                $display("FAIL disp_noblank v=%0d slot=%0d: an=%b seg=%b, expected an=%b seg=%b",
                         v, idx, an_nb, seg_nb, ea, es);
            end
        end
    endtask

    // One complete conversion: checks busy length, done position/count, bcd and flag_led.
    task automatic run_conv(input int v, input bit f);
        int busy_cnt, done_cnt, done_at;
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = -1;
        @(negedge clk);
        result = 16'(v);
        flag   = f;
        load   = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int k = 0; k < 24; k++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            @(negedge clk);
        end
        n_checks++;
        if (busy_cnt != 17) begin
            n_errors++;
            $display("FAIL busy_len v=%0d: got %0d cycles, expected 17", v, busy_cnt);
        end
        n_checks++;
        if (done_cnt != 1 || done_at != 17) begin
            n_errors++;
            $display("FAIL done_pulse v=%0d: %0d pulses first at %0d, expected 1 at 17",
                     v, done_cnt, done_at);
        end
        n_checks++;
        if (bcd !== to_bcd(v) || bcd_nb !== to_bcd(v)) begin
            n_errors++;
            $display("FAIL bcd v=%0d: got %h/%h, expected %h", v, bcd, bcd_nb, to_bcd(v));
        end
        n_checks++;
        if (flag_led !== f) begin
            n_errors++;
            $display("FAIL flag_led v=%0d: got %b, expected %b", v, flag_led, f);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || bcd !== 20'h0 || flag_led !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_regs: busy=%b done=%b bcd=%h flag_led=%b, expected 0 0 00000 0",
                     busy, done, bcd, flag_led);
        end
        n_checks++;
        if (an !== 5'b11110 || seg !== 7'b1000000) begin
            n_errors++;
            $display("FAIL reset_disp: an=%b seg=%b, expected 11110 1000000", an, seg);
        end
        rst = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || bcd !== 20'h0) begin
            n_errors++;
            $display("FAIL idle_after_reset: busy=%b done=%b bcd=%h, expected 0 0 00000",
                     busy, done, bcd);
        end
        check_display(10, 0);
    endtask

    task automatic test_basic();
        run_conv(255, 1'b0);
        check_display(25, 255);
    endtask

    task automatic test_back_to_back();
        int at;
        @(negedge clk);
        result = 16'd65535;
        flag   = 1'b1;
        load   = 1'b1;
        @(negedge clk);
        load = 1'b0;
        at = -1;
        for (int k = 0; k < 30; k++) begin
            if (done) begin at = k; break; end
            @(negedge clk);
        end
        n_checks++;
        if (at != 17 || bcd !== 20'h65535) begin
            n_errors++;
            $display("FAIL b2b_first: done at %0d bcd=%h, expected 17 65535", at, bcd);
        end
        // Still inside the done cycle: the FSM is already idle and must accept this.
        result = 16'd0;
        flag   = 1'b0;
        load   = 1'b1;
        @(negedge clk);
        load = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_accept: busy=%b done=%b, expected 1 0", busy, done);
        end
        at = -1;
        for (int k = 0; k < 30; k++) begin
            if (done) begin at = k; break; end
            @(negedge clk);
        end
        n_checks++;
        if (at != 17 || bcd !== 20'h00000 || flag_led !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_second: done at %0d bcd=%h flag_led=%b, expected 17 00000 0",
                     at, bcd, flag_led);
        end
    endtask

    task automatic test_ignored_load();
        int done_cnt;
        @(negedge clk);
        result = 16'd1234;
        flag   = 1'b1;
        load   = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (5) @(negedge clk);
        result = 16'd999;
        flag   = 1'b0;
        load   = 1'b1;
        @(negedge clk);
        load = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            if (done) done_cnt++;
            @(negedge clk);
        end
        n_checks++;
        if (done_cnt != 1 || bcd !== 20'h01234 || flag_led !== 1'b1) begin
            n_errors++;
            $display("FAIL ignored_load: pulses=%0d bcd=%h flag_led=%b, expected 1 01234 1",
                     done_cnt, bcd, flag_led);
        end
        check_display(25, 1234);
    endtask

    task automatic test_reset_mid();
        int done_cnt;
        @(negedge clk);
        result = 16'd4321;
        flag   = 1'b1;
        load   = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || bcd !== 20'h0 || flag_led !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_reset_regs: busy=%b done=%b bcd=%h flag_led=%b, expected 0 0 00000 0",
                     busy, done, bcd, flag_led);
        end
        n_checks++;
        if (an !== 5'b11110 || seg !== 7'b1000000) begin
            n_errors++;
            $display("FAIL mid_reset_disp: an=%b seg=%b, expected 11110 1000000", an, seg);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 25; k++) begin
            if (done) done_cnt++;
            @(negedge clk);
        end
        n_checks++;
        if (done_cnt != 0 || bcd !== 20'h0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_reset_abort: pulses=%0d bcd=%h busy=%b, expected 0 00000 0",
                     done_cnt, bcd, busy);
        end
        run_conv(4321, 1'b0);
        check_display(10, 4321);
    endtask

    task automatic test_random();
        int v;
        bit f;
        int edges[8] = '{0, 9, 10, 99, 100, 9999, 10000, 65535};
        for (int i = 0; i < 8; i++) begin
            f = 1'($urandom);
            run_conv(edges[i], f);
            check_display(5, edges[i]);
        end
        for (int i = 0; i < 12; i++) begin
            v = int'($urandom_range(0, 65535));
            f = 1'($urandom);
            run_conv(v, f);
            check_display(5, v);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_ignored_load();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/result_bcd_display.md
Name: result_bcd_display

Overview:
Consumer of the calculator ALU's 16-bit binary result and status flag. On a load pulse it captures the result and converts it to five packed BCD digits with a sequential double-dabble engine (shift-add-3). It then time-multiplexes the digits onto a 5-digit common-anode 7-segment display. It sits between the ALU result bus and the board display pins.

Parameters:
REFRESH_DIV, 50000, clk cycles each digit stays lit during the display scan (minimum 2).
BLANK_LEADING, 1, when 1 blank leading zeros on digits 4..1; digit 0 is always shown.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous reset, active-low
result  input  16  unsigned binary ALU result
flag  input  1  ALU status flag (carry/borrow/overflow/div0)
load  input  1  single-cycle request to capture result and flag and start a conversion
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse: new bcd value valid
bcd  output  20  packed BCD digits; [19:16] = ten-thousands, [3:0] = units
seg  output  7  segments {g,f,e,d,c,b,a}, active-low
an  output  5  digit enables, active-low, one-hot; an[0] = units
flag_led  output  1  flag value captured at the last accepted load

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, busy=0, done=0, bcd=0, flag_led=0, prescaler=0, scan index=0, an=5'b11110, seg=7'b1000000 ("0").
- FSM states are IDLE, CONVERT and FINISH.
- IDLE: load=1 at edge E0 captures result into the shift register and flag into flag_led. It clears the 20-bit working register and the bit counter, sets busy=1 and moves to CONVERT. load=0 keeps the FSM in IDLE.
- CONVERT, at each of edges E1..E16:
  - first add 3 to every working nibble that is >=5;
  - then shift {working, shift} left by 1;
  - increment the counter.
  - After the shift at E16 the FSM moves to FINISH.
- FINISH, at edge E17: bcd <= working register, done=1 for exactly the following cycle, busy=0, state returns to IDLE.
- Latency: load sampled at E0 gives done high in the cycle after E17. busy is high for cycles E0..E16 (17 cycles).
- load is accepted only in IDLE. load in CONVERT or FINISH is ignored and does not change the captured result or flag_led.
- A new load may be accepted in the same cycle that done is high, because the FSM is already in IDLE.
- bcd and flag_led hold their values between conversions. The display reads only the bcd register, so it is undisturbed while a conversion runs.
- Range: 0..65535 maps to 20'h00000..20'h65535. Digits 10..15 cannot occur; if one is ever decoded, seg=7'h7F (blank).
- Display scan:
  - The prescaler counts 0..REFRESH_DIV-1 freely, independent of the FSM.
  - When the prescaler wraps, the scan index advances 0,1,2,3,4,0,...
  - an drives low only the bit of the current index.
  - seg decodes the current digit with active-low encoding: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Leading-zero blanking (BLANK_LEADING=1): digit i (i>=1) is blank when digits 4..i are all zero. A blank slot drives an=5'b11111 and seg=7'h7F. With BLANK_LEADING=0 every digit is always shown.
- Reset mid-conversion: the conversion is aborted, no done pulse is produced, and the reset values above apply.

Test Plan:
- Release rst with no load for 10 cycles -> busy=0, done=0, bcd=20'h00000, an=11110, seg=1000000.
- load with result=16'd255 -> busy high 17 cycles, done pulses exactly once in the cycle after the 17th edge, bcd=20'h00255.
- Back-to-back loads with result=16'd65535 then 16'd0, the second load asserted in the done cycle -> bcd=20'h65535, then 17 cycles later bcd=20'h00000 with a second done pulse.
- load with result=16'd1234 and flag=1, then load with result=16'd999 and flag=0 at cycle 5 of the conversion -> a single done pulse, bcd=20'h01234, flag_led=1.
- REFRESH_DIV=4, bcd=20'h01234 -> an cycles every 4 clocks. Slot 4 is blank (an=11111, seg=7F); slots 3..0 show 1,2,3,4 with the correct patterns. With BLANK_LEADING=0, slot 4 shows 1000000 with an=01111.
- Assert rst at cycle 8 of the conversion of 16'd4321 -> busy=0 immediately, done never pulses, bcd=0. A later load of 16'd4321 gives bcd=20'h04321.
